// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, FSM state type.
// Ops 9-12 (madd/maddu/msub/msubu) count as start ops only when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;
  localparam int CNT_W       = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_start_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-facing bus of the multiply/divide unit: op/operands/cancel in, start/busy/HI/LO out.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cancel;
  logic             Start;
  logic             Busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output Op, A, B, Cancel, input Start, Busy, hi, lo);
  modport slave  (input Op, A, B, Cancel, output Start, Busy, hi, lo);
endinterface

// File: rtl/mdu_counter.sv
// IDLE/BUSY control FSM with a latency down-counter; done marks the final busy cycle.
module mdu_counter
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] lat,
  input  logic             cancel,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load && !cancel) begin
          state_nxt = BUSY;
          cnt_nxt   = lat;
        end
      end
      BUSY: begin
        if (cancel || cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == BUSY);
  assign done = busy && (cnt == CNT_W'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO; result commits as Busy falls.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate ops.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Low 2*WIDTH bits of the product are exact for both signednesses once operands are extended.
  function automatic logic [2*WIDTH-1:0] mul_prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] xe, ye;
    xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}; most-negative / -1 is pinned rather than left to overflow.
  function automatic logic [2*WIDTH-1:0] div_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic sgn);
    logic signed [WIDTH-1:0] xs, ys;
    logic [WIDTH-1:0] q, r;
    xs = x;
    ys = y;
    if (y == '0) begin
      q = '0;
      r = '0;
    end else if (sgn && x == MOST_NEG && y == '1) begin
      q = MOST_NEG;
      r = '0;
    end else if (sgn) begin
      q = xs / ys;
      r = xs % ys;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  logic               start, accept, busy, done, sgn;
  logic [CNT_W-1:0]   lat;
  logic [3:0]         op_p0;
  logic [WIDTH-1:0]   a_p0, b_p0, hi_r, lo_r;
  logic [2*WIDTH-1:0] prod, quot_rem;

  assign start  = is_start_op(bus.Op);
  assign accept = start && !busy && !bus.Cancel;
  assign lat    = is_div_op(bus.Op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  mdu_counter u_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .lat    (lat),
    .cancel (bus.Cancel),
    .busy   (busy),
    .done   (done)
  );

  // Stage p0: operands and op captured in the accept cycle, held for the whole busy window.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= bus.Op;
      a_p0  <= bus.A;
      b_p0  <= bus.B;
    end
  end

  assign sgn      = (op_p0 == OP_MULT) || (op_p0 == OP_DIV) || (op_p0 == OP_MADD) || (op_p0 == OP_MSUB);
  assign prod     = mul_prod(a_p0, b_p0, sgn);
  assign quot_rem = div_res(a_p0, b_p0, sgn);

  // Commit stage: HI/LO written on the edge that ends the last busy cycle, unless cancelled.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (done && !bus.Cancel) begin
      case (op_p0)
        OP_MULT, OP_MULTU: {hi_r, lo_r} <= prod;
        OP_DIV, OP_DIVU: begin
          if (b_p0 != '0) {hi_r, lo_r} <= quot_rem;
        end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: {hi_r, lo_r} <= {hi_r, lo_r} + prod;
        OP_MSUB, OP_MSUBU: {hi_r, lo_r} <= {hi_r, lo_r} - prod;
`endif
        default: ;
      endcase
    end else if (!busy) begin
      if (bus.Op == OP_MTHI) hi_r <= bus.A;
      if (bus.Op == OP_MTLO) lo_r <= bus.A;
    end
  end

  assign bus.Start = start;
  assign bus.Busy  = busy;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule
